// File: rtl/alu_pkg.sv
// Shared ALU encodings: operation classes and the 3-bit op codes within each class.
package alu_pkg;

    localparam logic [2:0] TYPE_ARITH = 3'd0;
    localparam logic [2:0] TYPE_SHIFT = 3'd1;
    localparam logic [2:0] TYPE_LOAD  = 3'd2;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_NOT = 3'd7;

    localparam logic [2:0] OP_SHR  = 3'd0;
    localparam logic [2:0] OP_SHL  = 3'd1;
    localparam logic [2:0] OP_ASHR = 3'd2;
    localparam logic [2:0] OP_ROR  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;

    localparam logic [2:0] OP_LD   = 3'd0;
    localparam logic [2:0] OP_LDL  = 3'd1;
    localparam logic [2:0] OP_LDH  = 3'd2;
    localparam logic [2:0] OP_SWP  = 3'd3;
    localparam logic [2:0] OP_LDLI = 3'd4;
    localparam logic [2:0] OP_LDHI = 3'd5;
    localparam logic [2:0] OP_LDLZ = 3'd6;
    localparam logic [2:0] OP_LDHZ = 3'd7;

endpackage

// File: rtl/alu_shifter.sv
// Combinational single-bit shift/rotate unit; rotates pass through the carry flag.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] operand,
    input  logic             carry_in,
    input  logic [2:0]       operation,
    output logic [WIDTH-1:0] result_c,
    output logic             carry_c
);

    always_comb begin
        result_c = operand;
        carry_c  = 1'b0;
        case (operation)
            OP_SHR: begin
                result_c = operand >> 1;
                carry_c  = operand[0];
            end
            OP_SHL: begin
                result_c = operand << 1;
                carry_c  = operand[WIDTH-1];
            end
            OP_ASHR: begin
                result_c = {operand[WIDTH-1], operand[WIDTH-1:1]};
                carry_c  = operand[0];
            end
            OP_ROR: begin
                result_c = {carry_in, operand[WIDTH-1:1]};
                carry_c  = operand[0];
            end
            OP_ROL: begin
                result_c = {operand[WIDTH-2:0], carry_in};
                carry_c  = operand[WIDTH-1];
            end
            default: begin
                result_c = operand;
                carry_c  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu.sv
// Single-cycle registered ALU: arithmetic/logic, shift/rotate and byte-load ops with flags.
// Optional macro ALU_OVERFLOW_EN adds the registered signed-overflow flag overflowOut.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             carryIn,
    input  logic [2:0]       operationType,
    input  logic [2:0]       operation,
    output logic [WIDTH-1:0] result,
    output logic             carryOut,
    output logic             zeroOut,
    output logic             negativeOut
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             overflowOut
`endif
);

    localparam int unsigned XW = WIDTH + 1;

    logic [WIDTH-1:0] shift_result_c;
    logic             shift_carry_c;
    logic             arith_cin_c;
    logic [XW-1:0]    sum_c;
    logic [XW-1:0]    diff_c;
    logic [WIDTH-1:0] res_c;
    logic             carry_c;

    alu_shifter #(.WIDTH(WIDTH)) u_shifter (
        .operand   (operand1),
        .carry_in  (carryIn),
        .operation (operation),
        .result_c  (shift_result_c),
        .carry_c   (shift_carry_c)
    );

    // ADC and SBC are the odd arithmetic codes; only they consume the incoming carry.
    assign arith_cin_c = carryIn & operation[0];
    assign sum_c       = {1'b0, operand1} + {1'b0, operand2} + XW'(arith_cin_c);
    assign diff_c      = {1'b0, operand1} - {1'b0, operand2} - XW'(arith_cin_c);

    always_comb begin
        res_c   = operand1;
        carry_c = 1'b0;
        case (operationType)
            TYPE_ARITH: begin
                case (operation)
                    OP_ADD, OP_ADC: begin
                        res_c   = sum_c[WIDTH-1:0];
                        carry_c = sum_c[WIDTH];
                    end
                    OP_SUB, OP_SBC: begin
                        res_c   = diff_c[WIDTH-1:0];
                        carry_c = diff_c[WIDTH];
                    end
                    OP_AND:  res_c = operand1 & operand2;
                    OP_OR:   res_c = operand1 | operand2;
                    OP_XOR:  res_c = operand1 ^ operand2;
                    default: res_c = ~operand1;
                endcase
            end
            TYPE_SHIFT: begin
                res_c   = shift_result_c;
                carry_c = shift_carry_c;
            end
            TYPE_LOAD: begin
                // Byte loads build a 16-bit value; anything above bit 15 is zero.
                case (operation)
                    OP_LD:            res_c = operand1;
                    OP_LDL, OP_LDLI:  res_c = WIDTH'({operand2[15:8], operand1[7:0]});
                    OP_LDH, OP_LDHI:  res_c = WIDTH'({operand1[7:0], operand2[7:0]});
                    OP_SWP:           res_c = WIDTH'({operand1[7:0], operand1[15:8]});
                    OP_LDLZ:          res_c = WIDTH'({8'h00, operand1[7:0]});
                    default:          res_c = WIDTH'({operand1[7:0], 8'h00});
                endcase
            end
            default: begin
                res_c   = operand1;
                carry_c = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result      <= '0;
            carryOut    <= 1'b0;
            zeroOut     <= 1'b0;
            negativeOut <= 1'b0;
        end else begin
            result      <= res_c;
            carryOut    <= carry_c;
            zeroOut     <= (res_c == '0);
            negativeOut <= res_c[WIDTH-1];
        end
    end

`ifdef ALU_OVERFLOW_EN
    logic add_ovf_c;
    logic sub_ovf_c;
    logic ovf_c;

    assign add_ovf_c = (operand1[WIDTH-1] == operand2[WIDTH-1]) && (sum_c[WIDTH-1]  != operand1[WIDTH-1]);
    assign sub_ovf_c = (operand1[WIDTH-1] != operand2[WIDTH-1]) && (diff_c[WIDTH-1] != operand1[WIDTH-1]);

    always_comb begin
        ovf_c = 1'b0;
        if (operationType == TYPE_ARITH) begin
            case (operation)
                OP_ADD, OP_ADC: ovf_c = add_ovf_c;
                OP_SUB, OP_SBC: ovf_c = sub_ovf_c;
                default:        ovf_c = 1'b0;
            endcase
        end else if (operationType == TYPE_SHIFT && operation == OP_SHL) begin
            ovf_c = operand1[WIDTH-1] ^ operand1[WIDTH-2];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) overflowOut <= 1'b0;
        else       overflowOut <= ovf_c;
    end
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed vectors plus random ops against an arithmetic reference model.
module tb_alu;

    localparam int unsigned W = 16;

    typedef struct {
        logic [15:0] res;
        bit          c;
        bit          z;
        bit          n;
        bit          v;
        string       name;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  operand1 = '0;
    logic [W-1:0]  operand2 = '0;
    logic          carryIn = 1'b0;
    logic [2:0]    operationType = 3'd0;
    logic [2:0]    operation = 3'd0;
    logic [W-1:0]  result;
    logic          carryOut;
    logic          zeroOut;
    logic          negativeOut;
    logic          ovf;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    alu #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .operand1      (operand1),
        .operand2      (operand2),
        .carryIn       (carryIn),
        .operationType (operationType),
        .operation     (operation),
        .result        (result),
        .carryOut      (carryOut),
        .zeroOut       (zeroOut),
        .negativeOut   (negativeOut)
`ifdef ALU_OVERFLOW_EN
        ,
        .overflowOut   (ovf)
`endif
    );

`ifndef ALU_OVERFLOW_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    // Reference model using integer arithmetic on the op definitions.
    function automatic exp_t model(bit rst, logic [15:0] a, logic [15:0] b, bit cin,
                                   int typ, int op, string name);
        exp_t e;
        int ua = a;
        int ub = b;
        int sa = $signed(a);
        int sb_ = $signed(b);
        int ci = cin;
        int r = ua;
        int s;
        bit c = 0;
        bit v = 0;
        e.name = name;
        if (rst) begin
            e.res = 16'h0; e.c = 0; e.z = 0; e.n = 0; e.v = 0;
            return e;
        end
        if (typ == 0) begin
            case (op)
                0, 1: begin
                    s = ua + ub + (op == 1 ? ci : 0);
                    r = s; c = (s >= 65536);
                    s = sa + sb_ + (op == 1 ? ci : 0);
                    v = (s > 32767) || (s < -32768);
                end
                2, 3: begin
                    s = ua - ub - (op == 3 ? ci : 0);
                    r = s; c = (s < 0);
                    s = sa - sb_ - (op == 3 ? ci : 0);
                    v = (s > 32767) || (s < -32768);
                end
                4: r = ua & ub;
                5: r = ua | ub;
                6: r = ua ^ ub;
                default: r = ~ua;
            endcase
        end else if (typ == 1) begin
            case (op)
                0: begin r = ua / 2; c = ua % 2; end
                1: begin r = ua * 2; c = (ua / 32768) % 2; v = ((ua / 32768) % 2) != ((ua / 16384) % 2); end
                2: begin r = (sa - (ua % 2)) / 2; c = ua % 2; end
                3: begin r = ua / 2 + ci * 32768; c = ua % 2; end
                4: begin r = ua * 2 + ci; c = (ua / 32768) % 2; end
                default: r = ua;
            endcase
        end else if (typ == 2) begin
            int alo = ua % 256;
            int ahi = (ua / 256) % 256;
            int blo = ub % 256;
            int bhi = (ub / 256) % 256;
            case (op)
                0:       r = ua;
                1, 4:    r = bhi * 256 + alo;
                2, 5:    r = alo * 256 + blo;
                3:       r = alo * 256 + ahi;
                6:       r = alo;
                default: r = alo * 256;
            endcase
        end
        r = r & 32'hFFFF;
        e.res = 16'(r);
        e.c   = c;
        e.z   = (r == 0);
        e.n   = (r >= 32768);
        e.v   = v;
`ifndef ALU_OVERFLOW_EN
        e.v   = 0;
`endif
        return e;
    endfunction

    task automatic drive(bit rst, logic [15:0] a, logic [15:0] b, bit cin,
                         int typ, int op, string name);
        @(negedge clk);
        reset         = rst;
        operand1      = a;
        operand2      = b;
        carryIn       = cin;
        operationType = 3'(typ);
        operation     = 3'(op);
        sb.push_back(model(rst, a, b, cin, typ, op, name));
    endtask

    function automatic logic [15:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom());
        endcase
    endfunction

    // Monitor: every cycle the DUT presents one registered response.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (result !== e.res || carryOut !== e.c || zeroOut !== e.z ||
                    negativeOut !== e.n || ovf !== e.v) begin
                    failures++;
                    $display("FAIL %s: got res=%h c=%b z=%b n=%b v=%b, want res=%h c=%b z=%b n=%b v=%b",
                             e.name, result, carryOut, zeroOut, negativeOut, ovf,
                             e.res, e.c, e.z, e.n, e.v);
                end
            end
        end
    end

    initial begin
        drive(1, 16'h0000, 16'h0000, 0, 0, 0, "reset_state");
        drive(0, 16'hFFFF, 16'h0001, 0, 0, 0, "add_wrap");
        drive(0, 16'h0003, 16'h0005, 0, 0, 2, "sub_borrow");
        drive(0, 16'h0005, 16'h0005, 1, 0, 3, "sbc_borrow");
        drive(0, 16'h7FFF, 16'h0000, 1, 0, 1, "adc_ovf");
        drive(0, 16'h0001, 16'h0000, 1, 1, 3, "ror_cin");
        drive(0, 16'h8002, 16'h0000, 0, 1, 2, "ashr_neg");
        drive(0, 16'h8000, 16'h0000, 0, 1, 4, "rol_zero");
        drive(0, 16'h4000, 16'h0000, 0, 1, 1, "shl_ovf");
        drive(0, 16'h1234, 16'h0000, 0, 2, 3, "swp");
        drive(0, 16'h0055, 16'hAA00, 0, 2, 4, "ldli");
        drive(0, 16'h12AB, 16'h0000, 0, 2, 7, "ldhz");
        drive(0, 16'h0000, 16'h0000, 0, 2, 6, "ldlz_zero");
        drive(0, 16'hBEEF, 16'h1234, 1, 5, 0, "bad_type");
        drive(0, 16'hBEEF, 16'h0000, 1, 1, 6, "shift_unused");
        drive(1, 16'h0001, 16'h0001, 0, 0, 0, "reset_priority");
        drive(0, 16'h0001, 16'h0001, 0, 0, 0, "first_after_reset");

        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 31) == 0), rand_operand(), rand_operand(),
                  1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7), "random");
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d responses outstanding, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
